rom_port_arbiter: RTL and testbench
===================================

# rom_port_arbiter

Shares the single data read port of the instruction/constant ROM between `NUM_REQ` requesters (core load unit, debug module, boot loader) using round-robin arbitration. Each requester sees a valid/ready request channel and a valid/ready response channel. The arbiter drives the ROM data-port address and enable, captures the synchronous read data, and checks address range and alignment. It sits between the requesters and the ROM's `mem_*` port; the ROM instruction port is not touched.

## Interface
- `MEM_DEPTH`, 256: ROM depth in 32-bit words; must match the ROM instance.
- `NUM_REQ`, 2: number of requesters, 2..4.
- `clk_i` in 1: system clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_valid_i` in `NUM_REQ`: per-requester read request valid.
- `req_addr_i` in `NUM_REQ`x32: packed byte addresses; requester i uses `[i][31:0]`.
- `req_ready_o` out `NUM_REQ`: one-hot grant/accept.
- `rsp_valid_o` out `NUM_REQ`: one-hot response valid, same index as the granted request.
- `rsp_ready_i` in `NUM_REQ`: per-requester response accept.
- `rsp_rdata_o` out 32: shared response data.
- `rsp_err_o` out 1: shared error flag, qualified by `rsp_valid_o`.
- `rom_en_o` out 1: ROM data-port enable.
- `rom_addr_o` out `$clog2(MEM_DEPTH)`: ROM word address, equal to byte address `[AW+1:2]`.
- `rom_rdata_i` in 32: ROM data-port read data, valid one cycle after `rom_en_o`.

## Operation
- FSM states and transitions:
  - IDLE: if any `req_valid_i`, grant the winner k.
    - Address good: go to READ.
    - Address bad: go to RESP with err=1 and rdata=0.
  - READ: capture `rom_rdata_i` into the response register, err=0, then go to RESP.
  - RESP: drive `rsp_valid_o[k]=1`; on `rsp_ready_i[k]` go to IDLE.
- Grant in IDLE: `req_ready_o[k]=1` for exactly that cycle. Request handshake = `req_valid_i[k] & req_ready_o[k]`.
- Address latch: k and the address are registered at grant. Requesters may drop or change `req_addr_i` after the handshake.
- ROM drive for a good address: `rom_en_o=1` and `rom_addr_o=req_addr_i[k][AW+1:2]` combinationally in the grant cycle. `rom_en_o=0` in all other cycles.
- Address is bad if either holds:
  - `addr[1:0]!=0` (misaligned).
  - `addr >= MEM_DEPTH*4` (out of range; compare the full 32 bits, no truncation).
- Bad addresses never assert `rom_en_o`.
- Round robin:
  - Pointer p gives priority order p, p+1, …, wrapping mod `NUM_REQ`.
  - After a grant to k, p becomes (k+1) mod `NUM_REQ`.
  - The pointer only moves on a grant.
- Response register holds `rsp_rdata_o` and `rsp_err_o` stable throughout RESP, regardless of ROM output.
- `req_ready_o` is 0 in READ and RESP; there is one outstanding transaction at most.

## Timing
- Reset values: FSM=IDLE, p=0, `req_ready_o=0` (while in reset), `rsp_valid_o=0`, `rsp_rdata_o=0`, `rsp_err_o=0`, `rom_en_o=0`, `rom_addr_o=0`.
- Good read: grant at cycle T, `rom_en_o` at T, `rsp_valid_o` at T+2. With immediate `rsp_ready_i`, the next grant is at T+3. Minimum period is 3 cycles.
- Bad read: grant at T, `rsp_valid_o` at T+1, next grant earliest at T+2.
- `req_ready_o` depends combinationally on `req_valid_i` and registered state only, never on `rsp_ready_i`.
- Response stall: `rsp_valid_o` stays high indefinitely until accepted; data and err are held.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers wait, with `req_valid_i` held high by protocol.
- Reset asserted mid-transaction (READ or RESP): immediate return to IDLE. The response is lost and no `rsp_valid_o` is issued for it.
- Boundary address `MEM_DEPTH*4-4` is good. `MEM_DEPTH*4` is bad.

## Structure
- Package `rom_arb_pkg`:
  - `typedef enum logic [1:0] {IDLE, READ, RESP} rom_arb_state_t`.
  - `localparam` helper for `AW = $clog2(MEM_DEPTH)`.
  - Function `addr_ok(addr, depth)`.
- Sub-module `rr_arbiter #(N)`:
  - Inputs: `clk_i`, `rst_i`, `req_i[N]`, `advance_i`.
  - Output: `grant_o[N]`, one-hot.
  - Owns pointer p; updates p on `advance_i`.
- Top level holds the FSM, latched index and address, response register, and address check.

## Test plan
- Single read: r0 reads 0x0000_0010 with ROM word 4 = 0xDEAD_BEEF → `rom_en_o` at T with `rom_addr_o`=4; `rsp_valid_o`=01 at T+2 with rdata 0xDEAD_BEEF and err=0.
- Contention: r0 and r1 both valid continuously, 4 transactions → grant order r0, r1, r0, r1; never two bits set in `req_ready_o`.
- Errors: r1 reads 0x0000_0002 and then 0x0000_0400 (`MEM_DEPTH`=256) → each responds at T+1 with err=1 and rdata=0, and `rom_en_o` never asserts. 0x0000_03FC reads word 255 with err=0.
- Backpressure: `rsp_ready_i`=0 for 10 cycles → `rsp_valid_o` and data stable; no new grant while r0 is pending; accept, then grant the next cycle.
- Reset mid-READ: assert `rst_i` at T+1 → all outputs reset that cycle and no response appears. After release, r0 re-requests and completes normally with p=0.
- Pointer wrap: `NUM_REQ`=3 with only r2 valid, then r0 and r1 valid together → r0 wins, since p wraps to 0 after the grant to r2.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared types and helpers for the ROM data-port arbiter.
package rom_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } rom_arb_state_t;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Range compare is done on 34 bits so large byte addresses never alias into the ROM.
  function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth);
    logic [33:0] limit;
    limit = {depth[31:0], 2'b00};
    return (addr[1:0] == 2'b00) && ({2'b00, addr} < limit);
  endfunction

endpackage

// File: rtl/rom_port_arbiter_rr.sv
// Round-robin one-hot grant generator; the priority pointer moves only on a taken grant.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  input  logic         advance_i,
  output logic [N-1:0] grant_o
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] win;
  logic          found;
  int unsigned   idx;

  always_comb begin
    grant_o = '0;
    win     = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr_q) + i) % N;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        win          = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (advance_i && found) begin
      ptr_q <= (win == PW'(N - 1)) ? '0 : PW'(win + 1'b1);
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Round-robin sharing of the ROM data read port with range/alignment checking.
module rom_port_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned NUM_REQ   = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ-1:0][31:0]     req_addr_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  output logic [NUM_REQ-1:0]           rsp_valid_o,
  input  logic [NUM_REQ-1:0]           rsp_ready_i,
  output logic [31:0]                  rsp_rdata_o,
  output logic                         rsp_err_o,
  output logic                         rom_en_o,
  output logic [$clog2(MEM_DEPTH)-1:0] rom_addr_o,
  input  logic [31:0]                  rom_rdata_i
);

  localparam int unsigned AW = addr_width(MEM_DEPTH);
  localparam int unsigned KW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  rom_arb_state_t    state_q;
  logic [KW-1:0]     idx_q;
  logic [KW-1:0]     grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic [31:0]       sel_addr;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              granting;
  logic              sel_good;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_valid_i),
    .advance_i (granting),
    .grant_o   (grant)
  );

  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_idx = KW'(i);
    end
  end

  // Grant path sees only request valids and registered state, and is held off during reset.
  always_comb begin
    sel_addr    = req_addr_i[grant_idx];
    sel_good    = addr_ok(sel_addr, MEM_DEPTH);
    req_ready_o = (state_q == IDLE && !rst_i) ? grant : '0;
    granting    = |req_ready_o;
    rom_en_o    = granting & sel_good;
    rom_addr_o  = rom_en_o ? sel_addr[AW+1:2] : '0;
  end

  always_comb begin
    rsp_valid_o = '0;
    if (state_q == RESP) rsp_valid_o[idx_q] = 1'b1;
  end

  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (granting) begin
            idx_q <= grant_idx;
            if (sel_good) begin
              state_q <= READ;
            end else begin
              rdata_q <= '0;
              err_q   <= 1'b1;
              state_q <= RESP;
            end
          end
        end
        READ: begin
          rdata_q <= rom_rdata_i;
          err_q   <= 1'b0;
          state_q <= RESP;
        end
        RESP: begin
          if (rsp_ready_i[idx_q]) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Randomized bench for rom_port_arbiter against a transaction-level latency model.
module tb_rom_port_arbiter;

  localparam int unsigned N     = 3;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned CYCLES = 4000;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       req_valid;
  logic [N-1:0][31:0] req_addr;
  logic [N-1:0]       req_ready;
  logic [N-1:0]       rsp_valid;
  logic [N-1:0]       rsp_ready;
  logic [31:0]        rsp_rdata;
  logic               rsp_err;
  logic               rom_en;
  logic [7:0]         rom_addr;
  logic [31:0]        rom_rdata;

  logic [31:0] rom [DEPTH];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rom_port_arbiter #(.MEM_DEPTH(DEPTH), .NUM_REQ(N)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_addr_i  (req_addr),
    .req_ready_o (req_ready),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .rom_en_o    (rom_en),
    .rom_addr_o  (rom_addr),
    .rom_rdata_i (rom_rdata)
  );

  // Synchronous ROM; output scrambles when not enabled so held responses are really held.
  always @(posedge clk) begin
    if (rom_en) rom_rdata <= rom[rom_addr];
    else        rom_rdata <= $urandom();
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_good(input logic [31:0] a);
    longint unsigned v;
    v = longint'(a);
    return (v % 4 == 0) && (v < 4 * DEPTH);
  endfunction

  function automatic logic [31:0] gen_addr();
    logic [31:0] a;
    case ($urandom_range(0, 11))
      0:       a = 32'h0000_03FC;
      1:       a = 32'h0000_0400;
      2:       a = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
      3:       a = 32'h0001_0010;
      4:       a = 32'hFFFF_FFFC;
      5:       a = 32'h0000_0010;
      6:       a = 32'h0000_0002;
      default: a = 32'($urandom_range(0, 255)) << 2;
    endcase
    return a;
  endfunction

  bit          busy;
  int          k, wait_n, p, win;
  logic [31:0] exp_data;
  logic        exp_err;
  bit          pend [N];
  logic [31:0] paddr [N];
  int          stall;
  bit          rst_now, good;
  logic [31:0] a, exp_ready, exp_valid;
  int          n_good_rsp, n_err_rsp, n_rst_busy, n_long_stall;

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = $urandom();
    rom[4]   = 32'hDEAD_BEEF;
    rom[255] = 32'hCAFE_F00D;

    rst       = 1'b1;
    req_valid = '1;
    req_addr  = '0;
    rsp_ready = '0;
    busy = 0; p = 0; k = 0; wait_n = 0; stall = 0;
    exp_data = '0; exp_err = 1'b0;
    n_good_rsp = 0; n_err_rsp = 0; n_rst_busy = 0; n_long_stall = 0;
    for (int i = 0; i < N; i++) begin
      pend[i]  = 0;
      paddr[i] = '0;
    end

    @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'h0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rdata", rsp_rdata, 32'h0);
    check("reset_err", 32'(rsp_err), 32'h0);
    check("reset_rom_en", 32'(rom_en), 32'h0);
    check("reset_rom_addr", 32'(rom_addr), 32'h0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = '0;

    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      // Drive: requesters hold valid and address until their handshake.
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i]  = 1;
          paddr[i] = gen_addr();
        end
        req_valid[i] = pend[i];
        req_addr[i]  = paddr[i];
      end
      if (stall == 0 && $urandom_range(0, 39) == 0) begin
        stall = 10;
        if (busy) n_long_stall++;
      end
      if (stall > 0) begin
        rsp_ready = '0;
        stall--;
      end else begin
        for (int i = 0; i < N; i++) rsp_ready[i] = ($urandom_range(0, 3) != 0);
      end
      rst_now = ($urandom_range(0, 59) == 0);
      rst     = rst_now;
      if (rst_now) begin
        if (busy) n_rst_busy++;
        busy = 0;
        p    = 0;
      end

      @(negedge clk);
      win = -1;
      if (!rst_now && !busy) begin
        for (int j = 0; j < N; j++) begin
          if (win < 0 && pend[(p + j) % N]) win = (p + j) % N;
        end
      end
      exp_ready = (win >= 0) ? (32'd1 << win) : 32'd0;
      good      = (win >= 0) && model_good(paddr[win >= 0 ? win : 0]);
      exp_valid = (busy && wait_n == 0) ? (32'd1 << k) : 32'd0;

      check("req_ready", 32'(req_ready), exp_ready);
      check("rom_en", 32'(rom_en), 32'(good));
      check("rsp_valid", 32'(rsp_valid), exp_valid);
      if (good) begin
        a = paddr[win];
        check("rom_addr", 32'(rom_addr), 32'(a[9:2]));
      end
      if (exp_valid != 0) begin
        check("rsp_rdata", rsp_rdata, exp_data);
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        if (exp_err) n_err_rsp++;
        else         n_good_rsp++;
      end
      if (rst_now) begin
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_err", 32'(rsp_err), 32'h0);
      end

      @(posedge clk);
      #1;
      if (rst_now) begin
        rst = 1'b0;
      end else if (win >= 0) begin
        busy      = 1;
        k         = win;
        p         = (win + 1) % N;
        pend[win] = 0;
        if (good) begin
          a        = paddr[win];
          wait_n   = 1;
          exp_data = rom[a[9:2]];
          exp_err  = 1'b0;
        end else begin
          wait_n   = 0;
          exp_data = 32'h0;
          exp_err  = 1'b1;
        end
      end else if (busy && wait_n > 0) begin
        wait_n--;
      end else if (busy && rsp_ready[k]) begin
        busy = 0;
      end
    end

    check("seen_good_rsp", 32'(n_good_rsp > 0), 32'h1);
    check("seen_err_rsp", 32'(n_err_rsp > 0), 32'h1);
    check("seen_rst_busy", 32'(n_rst_busy > 0), 32'h1);
    check("seen_long_stall", 32'(n_long_stall > 0), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
